// File: rtl/uart_cmd_led_ctrl.sv
// ============================================================================
// Module      : uart_cmd_led_ctrl
// Description : UART command decoder and N-channel status / PWM LED driver.
//               Parses framed commands from the UART receive byte stream,
//               maintains one status bit and one brightness level per channel,
//               drives PWM-dimmed LEDs, and returns a one-byte ACK ("K") or
//               NAK ("N") through a valid/ready transmit handshake. A frame
//               that stays idle too long is dropped and flagged.
//
//               Frame formats (bytes in order):
//                 CLEAR : CMD_CLEAR, arg, CMD_CLEAR
//                 LEVEL : CMD_LEVEL, arg, value, CMD_LEVEL
//               arg selects channel (arg - BASE_CHAR); for CLEAR, arg equal
//               to RESET_ARG restores every channel's status bit.
//
// Ports       : clk        - system clock
//               reset      - synchronous, active-high reset
//               rx_data    - received byte
//               rx_valid   - one-cycle strobe qualifying rx_data
//               tx_data    - response byte (0x4B ACK / 0x4E NAK)
//               tx_valid   - response pending
//               tx_ready   - consumer accepts tx_data when tx_valid && tx_ready
//               ch_status  - per-channel status (1 = alive, 0 = cleared)
//               led        - per-channel PWM-gated LED drive (registered)
//               frame_err  - one-cycle pulse when a frame times out
//
// Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module uart_cmd_led_ctrl #(
    parameter int NUM_CH      = 8,
    parameter int PWM_BITS    = 4,
    parameter int BASE_CHAR   = 65,
    parameter int CMD_CLEAR   = 65,
    parameter int CMD_LEVEL   = 66,
    parameter int RESET_ARG   = 96,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [NUM_CH-1:0] ch_status,
    output logic [NUM_CH-1:0] led,
    output logic              frame_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [7:0] c_ack       = 8'h4B;
    localparam logic [7:0] c_nak       = 8'h4E;
    localparam logic [7:0] c_base      = 8'(BASE_CHAR);
    localparam logic [7:0] c_cmd_clear = 8'(CMD_CLEAR);
    localparam logic [7:0] c_cmd_level = 8'(CMD_LEVEL);
    localparam logic [7:0] c_reset_arg = 8'(RESET_ARG);
    localparam logic [7:0] c_num_ch    = 8'(NUM_CH);

    // A single-cycle timeout would give a zero-width counter; keep at least 1 bit.
    localparam int                c_to_w    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYC - 1);

    localparam logic [PWM_BITS-1:0] c_level_max = {PWM_BITS{1'b1}};

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARG  = 3'd1,
        ST_VAL  = 3'd2,
        ST_TERM = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t                r_state;
    logic [7:0]            r_cmd;
    logic [7:0]            r_arg;
    logic [PWM_BITS-1:0]   r_lvl;
    logic [PWM_BITS-1:0]   r_level [NUM_CH];
    logic [c_to_w-1:0]     r_to_cnt;
    logic [PWM_BITS-1:0]   r_pwm_cnt;

    // ------------------------------------------------------------------------
    // Command validity (only meaningful on the terminator cycle)
    // ------------------------------------------------------------------------
    logic [7:0] w_idx;
    logic       w_in_range;
    logic       w_is_reset_arg;
    logic       w_term_ok;
    logic       w_is_clear;
    logic       w_is_level;
    logic       w_accept;
    logic       w_in_frame;
    logic       w_expire;

    always_comb begin
        // 8-bit wrap on subtract is harmless: the >= guard rejects wrapped values.
        w_idx          = r_arg - c_base;
        w_in_range     = (r_arg >= c_base) && (w_idx < c_num_ch);
        w_is_reset_arg = (r_arg == c_reset_arg);
        w_term_ok      = (rx_data == r_cmd);
        w_is_clear     = (r_cmd == c_cmd_clear);
        w_is_level     = (r_cmd == c_cmd_level);
        w_accept       = w_term_ok &&
                         ((w_is_clear && (w_in_range || w_is_reset_arg)) ||
                          (w_is_level && w_in_range));

        w_in_frame = (r_state == ST_ARG) || (r_state == ST_VAL) || (r_state == ST_TERM);
        // An arriving byte takes priority over an expiring counter.
        w_expire   = w_in_frame && !rx_valid && (r_to_cnt == c_to_last);
    end

    // ------------------------------------------------------------------------
    // Inter-byte timeout counter: runs only while a frame is open
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (!w_in_frame || rx_valid || w_expire) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Frame parser FSM with registered response, status and level state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cmd     <= '0;
            r_arg     <= '0;
            r_lvl     <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            frame_err <= 1'b0;
            ch_status <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                r_level[i] <= c_level_max;
            end
        end else begin
            frame_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // Anything other than a known command opener is noise.
                    if (rx_valid && ((rx_data == c_cmd_clear) || (rx_data == c_cmd_level))) begin
                        r_cmd   <= rx_data;
                        r_state <= ST_ARG;
                    end
                end

                ST_ARG: begin
                    if (rx_valid) begin
                        r_arg   <= rx_data;
                        r_state <= w_is_level ? ST_VAL : ST_TERM;
                    end else if (w_expire) begin
                        r_state   <= ST_IDLE;
                        frame_err <= 1'b1;
                    end
                end

                ST_VAL: begin
                    if (rx_valid) begin
                        r_lvl   <= rx_data[PWM_BITS-1:0];
                        r_state <= ST_TERM;
                    end else if (w_expire) begin
                        r_state   <= ST_IDLE;
                        frame_err <= 1'b1;
                    end
                end

                ST_TERM: begin
                    if (rx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= w_accept ? c_ack : c_nak;
                        r_state  <= ST_RESP;

                        if (w_accept) begin
                            if (w_is_clear && !w_in_range) begin
                                // Only reachable via RESET_ARG; levels are left alone.
                                ch_status <= '1;
                            end else begin
                                for (int i = 0; i < NUM_CH; i++) begin
                                    if (w_idx == 8'(i)) begin
                                        if (w_is_clear) begin
                                            ch_status[i] <= 1'b0;
                                        end else begin
                                            r_level[i] <= r_lvl;
                                        end
                                    end
                                end
                            end
                        end
                    end else if (w_expire) begin
                        r_state   <= ST_IDLE;
                        frame_err <= 1'b1;
                    end
                end

                ST_RESP: begin
                    // tx_data holds until accepted; incoming bytes are dropped here.
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Free-running PWM counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // LED drive: a cleared channel lights, dimmed by its level.
    // Strict < makes level 0 fully off and max level on for all but one slot.
    // ------------------------------------------------------------------------
    logic [NUM_CH-1:0] w_led_next;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_led
            assign w_led_next[g] = ~ch_status[g] & (r_pwm_cnt < r_level[g]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            led <= '0;
        end else begin
            led <= w_led_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_led_ctrl.sv
// ============================================================================
// Module      : tb_uart_cmd_led_ctrl
// Description : Self-checking bench for uart_cmd_led_ctrl. Expected response
//               bytes are queued as frames are driven and popped as the DUT
//               presents them; a small model tracks status bits and levels.
// Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module tb_uart_cmd_led_ctrl;

    localparam int NUM_CH      = 8;
    localparam int PWM_BITS    = 4;
    localparam int TIMEOUT_CYC = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [NUM_CH-1:0] ch_status;
    logic [NUM_CH-1:0] led;
    logic              frame_err;

    int errors = 0;
    int checks = 0;

    logic [7:0]        exp_q[$];
    logic [NUM_CH-1:0] m_status;
    int                m_level[NUM_CH];

    uart_cmd_led_ctrl #(
        .NUM_CH      (NUM_CH),
        .PWM_BITS    (PWM_BITS),
        .BASE_CHAR   (65),
        .CMD_CLEAR   (65),
        .CMD_LEVEL   (66),
        .RESET_ARG   (96),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .ch_status (ch_status),
        .led       (led),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Helpers (drive / model only; comparisons live in the test tasks)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_status = '1;
        for (int i = 0; i < NUM_CH; i++) m_level[i] = 15;
        exp_q.delete();
    endtask

    task automatic send_clear(input logic [7:0] arg, input logic [7:0] term);
        int  idx;
        bit  ok;
        idx = int'(arg) - 65;
        ok  = (term == 8'h41) && (((idx >= 0) && (idx < NUM_CH)) || (arg == 8'h60));
        exp_q.push_back(ok ? 8'h4B : 8'h4E);
        if (ok) begin
            if (arg == 8'h60) m_status = '1;
            else              m_status[idx] = 1'b0;
        end
        send_byte(8'h41);
        send_byte(arg);
        send_byte(term);
    endtask

    task automatic send_level(input logic [7:0] arg, input logic [7:0] val,
                              input logic [7:0] term);
        int idx;
        bit ok;
        idx = int'(arg) - 65;
        ok  = (term == 8'h42) && (idx >= 0) && (idx < NUM_CH);
        exp_q.push_back(ok ? 8'h4B : 8'h4E);
        if (ok) m_level[idx] = int'(val[3:0]);
        send_byte(8'h42);
        send_byte(arg);
        send_byte(val);
        send_byte(term);
    endtask

    // ------------------------------------------------------------------------
    // Scenario tasks
    // ------------------------------------------------------------------------
    // Called right after a terminator; pops the scoreboard and, if tx_ready
    // is high, checks the handshake drops tx_valid on the next cycle.
    task automatic check_resp(input string name);
        int         w;
        logic [7:0] exp;
        w = 0;
        while (!tx_valid && w < 8) begin
            tick();
            w++;
        end
        checks++;
        if (tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: tx_valid=%b required 1 within 8 cycles", name, tx_valid);
        end else begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s_unexpected: tx_data=%h with empty scoreboard", name, tx_data);
            end else begin
                exp = exp_q.pop_front();
                if (tx_data !== exp) begin
                    errors++;
                    $display("FAIL %s_data: tx_data=%h required %h", name, tx_data, exp);
                end
            end
            checks++;
            if (w != 0) begin
                errors++;
                $display("FAIL %s_latency: tx_valid rose %0d cycles late required 0", name, w);
            end
            if (tx_ready) begin
                tick();
                checks++;
                if (tx_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_handshake: tx_valid=%b required 0", name, tx_valid);
                end
            end
        end
    endtask

    task automatic check_status(input string name);
        checks++;
        if (ch_status !== m_status) begin
            errors++;
            $display("FAIL %s_status: ch_status=%b required %b", name, ch_status, m_status);
        end
    endtask

    task automatic check_duty(input string name);
        int cnt[NUM_CH];
        int exp;
        for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < NUM_CH; i++) if (led[i] === 1'b1) cnt[i]++;
            tick();
        end
        for (int i = 0; i < NUM_CH; i++) begin
            exp = m_status[i] ? 0 : m_level[i];
            checks++;
            if (cnt[i] != exp) begin
                errors++;
                $display("FAIL %s_duty_ch%0d: led high %0d of 16 required %0d", name, i, cnt[i], exp);
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        model_reset();
        repeat (3) tick();
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || frame_err !== 1'b0 || led !== '0) begin
            errors++;
            $display("FAIL reset_outputs: tx_valid=%b tx_data=%h frame_err=%b led=%b required 0 00 0 0",
                     tx_valid, tx_data, frame_err, led);
        end
        check_status("reset");
        reset = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        send_clear(8'h43, 8'h41);
        check_resp("clear");
        check_status("clear");
        checks++;
        if (ch_status !== 8'b1111_1011) begin
            errors++;
            $display("FAIL clear_literal: ch_status=%b required 11111011", ch_status);
        end
        check_duty("clear");
    endtask

    task automatic test_out_of_range();
        send_clear(8'h49, 8'h41);          // idx 8: one past the last channel
        check_resp("oor");
        check_status("oor");
        send_clear(8'h40, 8'h41);          // below BASE_CHAR
        check_resp("below_base");
        check_status("below_base");
        send_clear(8'h60, 8'h41);          // restore all
        check_resp("restore");
        check_status("restore");
    endtask

    task automatic test_brightness();
        send_clear(8'h41, 8'h41);
        check_resp("clr_ch0");
        send_level(8'h41, 8'h03, 8'h42);
        check_resp("level3");
        check_duty("level3");
        send_level(8'h48, 8'h07, 8'h42);   // last channel, still not cleared
        check_resp("level_ch7");
        send_level(8'h49, 8'h05, 8'h42);   // out of range
        check_resp("level_oor");
        send_level(8'h41, 8'h00, 8'h42);
        check_resp("level0");
        check_duty("level0");
    endtask

    task automatic test_bad_term();
        send_clear(8'h42, 8'h42);
        check_resp("bad_term");
        check_status("bad_term");
        send_byte(8'h5A);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL stray_z_tx: tx_valid=%b required 0 at cycle %0d", tx_valid, k);
            end
            tick();
        end
        send_clear(8'h42, 8'h41);
        check_resp("after_stray");
        check_status("after_stray");
    endtask

    task automatic test_backpressure();
        bit stable;
        tx_ready = 1'b0;
        send_clear(8'h44, 8'h41);
        stable = 1'b1;
        // Extra bytes during RESP must be ignored (would clear ch4).
        send_byte(8'h41);
        send_byte(8'h45);
        send_byte(8'h41);
        for (int k = 0; k < 47; k++) begin
            if (tx_valid !== 1'b1 || exp_q.size() == 0 || tx_data !== exp_q[0]) stable = 1'b0;
            tick();
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL backpressure_hold: tx_valid=%b tx_data=%h not held for 50 cycles",
                     tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        check_resp("backpressure");
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_extra: tx_valid=%b required 0 at cycle %0d", tx_valid, k);
            end
            tick();
        end
        check_status("backpressure");
    endtask

    task automatic test_timeout();
        int fire_at;
        fire_at = -1;
        send_byte(8'h41);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (frame_err === 1'b1 && fire_at < 0) fire_at = k;
        end
        checks++;
        if (fire_at != TIMEOUT_CYC) begin
            errors++;
            $display("FAIL timeout_pulse: frame_err at cycle %0d required %0d", fire_at, TIMEOUT_CYC);
        end
        checks++;
        if (frame_err !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after: frame_err=%b tx_valid=%b required 0 0", frame_err, tx_valid);
        end
        // Back in IDLE: a fresh frame is accepted.
        send_clear(8'h46, 8'h41);
        check_resp("post_timeout");
        check_status("post_timeout");

        // A byte arriving exactly at expiry is processed instead.
        fire_at = -1;
        send_byte(8'h41);
        for (int k = 1; k < TIMEOUT_CYC; k++) begin
            if (frame_err === 1'b1) fire_at = k;
            tick();
        end
        exp_q.push_back(8'h4B);
        m_status[7] = 1'b0;
        send_byte(8'h48);
        if (frame_err === 1'b1) fire_at = TIMEOUT_CYC;
        send_byte(8'h41);
        checks++;
        if (fire_at >= 0) begin
            errors++;
            $display("FAIL timeout_coincide: frame_err at cycle %0d required none", fire_at);
        end
        check_resp("coincide");
        check_status("coincide");
    endtask

    task automatic test_reset_midframe();
        tx_ready = 1'b0;
        send_clear(8'h45, 8'h41);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: tx_valid=%b required 0", tx_valid);
        end
        check_status("reset_resp");
        tx_ready = 1'b1;

        send_byte(8'h41);
        send_byte(8'h42);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame: tx_valid=%b required 0", tx_valid);
        end
        check_status("reset_frame");

        // ch0 level was 0 before reset; it must be back at max.
        send_clear(8'h41, 8'h41);
        check_resp("post_reset");
        check_duty("post_reset");
    endtask

    initial begin
        test_reset();
        test_clear();
        test_out_of_range();
        test_brightness();
        test_bad_term();
        test_backpressure();
        test_timeout();
        test_reset_midframe();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_cmd_led_ctrl.md
Name: uart_cmd_led_ctrl

Overview:
Parametrised UART command decoder and N-channel status/LED driver, successor to the fixed 8-bit flag-status logic in the badge top level. It consumes bytes from the UART receive path, parses framed commands, and maintains a per-channel status bit and per-channel PWM brightness level. It drives dimmed LED outputs and returns a one-byte ACK/NAK through a valid/ready transmit handshake. Unterminated frames are discarded by a timeout.

Parameters:
NUM_CH, 8, number of status/LED channels (1..26)
PWM_BITS, 4, brightness resolution per channel
BASE_CHAR, 65, byte value mapping to channel 0 ("A")
CMD_CLEAR, 65, clear-channel command byte ("A")
CMD_LEVEL, 66, set-brightness command byte ("B")
RESET_ARG, 96, CLEAR argument that restores all channels ("`")
TIMEOUT_CYC, 1000000, maximum idle cycles between bytes inside a frame

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
tx_data  out  8  response byte: 0x4B "K" = ACK, 0x4E "N" = NAK
tx_valid  out  1  response pending
tx_ready  in  1  consumer accepts tx_data when tx_valid && tx_ready
ch_status  out  NUM_CH  1 = channel alive, 0 = cleared
led  out  NUM_CH  PWM-gated LED drive
frame_err  out  1  one-cycle pulse on frame timeout

Behaviour:
- Reset values:
  - ch_status = all 1; all levels = 2^PWM_BITS-1.
  - PWM counter = 0; FSM = IDLE; tx_valid = 0; tx_data = 0; frame_err = 0; led = 0.
  - Reset mid-frame or mid-response discards everything, with no response.
- FSM states: IDLE, ARG, VAL, TERM, RESP.
  - IDLE: a byte equal to CMD_CLEAR or CMD_LEVEL latches cmd and goes to ARG. Any other byte is ignored silently.
  - ARG: latch arg. CLEAR goes to TERM; LEVEL goes to VAL.
  - VAL: latch low PWM_BITS bits of the byte as lvl, go to TERM.
  - TERM: the byte is the terminator. It must equal the latched cmd, otherwise NAK. Go to RESP.
  - RESP: tx_valid = 1, tx_data held stable. On tx_valid && tx_ready: tx_valid goes to 0 next cycle and the FSM returns to IDLE. rx bytes arriving in RESP are dropped.
- Command validity, evaluated on the terminator cycle:
  - idx = arg - BASE_CHAR (8-bit unsigned subtract). In range iff arg >= BASE_CHAR and idx < NUM_CH (strict upper bound).
  - CLEAR with in-range idx: ch_status[idx] <= 0, ACK.
  - CLEAR with arg == RESET_ARG: ch_status <= all 1, ACK. Levels are unchanged.
  - LEVEL with in-range idx: level[idx] <= lvl, ACK.
  - Otherwise (out-of-range arg or terminator mismatch): NAK, no state change.
- Latency: ch_status/level update and tx_valid rise on the cycle after the terminator strobe.
- Timeout:
  - In ARG, VAL and TERM, a counter clears on each rx_valid and otherwise increments.
  - On reaching TIMEOUT_CYC-1: FSM goes to IDLE, frame_err pulses 1 cycle, no response, no state change.
  - If rx_valid coincides with expiry, the byte wins: it is processed and the counter restarts.
  - The counter is held at 0 in IDLE and RESP.
- PWM:
  - Free-running PWM_BITS counter, wraps 2^PWM_BITS-1 -> 0.
  - led[i] (registered) = ~ch_status[i] & (pwm_cnt < level[i]).
  - level 0 = always off; max level = on (2^B-1)/2^B of the period.
- Width rules: level is PWM_BITS wide; the timeout counter is $clog2(TIMEOUT_CYC) bits.

Test Plan:
- Defaults: after reset, send "A","C","A" -> ACK 0x4B; ch_status = 8'b1111_1011; led[2] high 15 of every 16 cycles; all other leds 0.
- Out of range: send "A","I","A" -> NAK 0x4E; ch_status unchanged (idx 8 rejected with NUM_CH = 8). Then send "A","`","A" -> ACK; ch_status = 8'hFF.
- Brightness: after clearing ch0, send "B","A",0x03,"B" -> ACK; led[0] high exactly 3 of every 16 cycles. Then send "B","A",0x00,"B" -> led[0] constantly 0.
- Bad terminator: send "A","B","B" -> NAK; ch_status unchanged. A stray "Z" in IDLE -> no response, FSM stays IDLE.
- Backpressure: hold tx_ready = 0 for 50 cycles after a valid frame -> tx_valid and tx_data stable, extra rx bytes dropped; raising tx_ready -> one handshake, then IDLE.
- Timeout and reset: with TIMEOUT_CYC = 16, send "A" then idle 15 cycles -> frame_err pulse, no tx; send "A","B" then assert reset -> ch_status = all 1, tx_valid = 0.
